// File: rtl/datapath_pkg.sv
// datapath_pkg: shared issue-stage types and scalar FU index constants.
package datapath_pkg;
    localparam int NUM_FU = 3;
    localparam int FU_W = 2;
    localparam int TAG_W = 2;
    localparam logic [FU_W-1:0] FU_ALU = 2'd0;
    localparam logic [FU_W-1:0] FU_LDST = 2'd1;
    localparam logic [FU_W-1:0] FU_BR = 2'd2;
    typedef enum logic [1:0] {IDLE, WAIT, READY, EXEC} issue_state_t;
    typedef logic [TAG_W-1:0] tag_t;
endpackage

// File: rtl/issue_s_slot.sv
// issue_s_slot: one FU slot FSM holding the producer tags of its in-flight op.
module issue_s_slot
    import datapath_pkg::*;
#(
    parameter int TAG_W = 2,
    parameter int IDX = 0
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             accept,
    input  logic [TAG_W-1:0] disp_t1,
    input  logic [TAG_W-1:0] disp_t2,
    input  logic             wb_valid,
    input  logic [TAG_W-1:0] wb_tag,
    input  logic             iss_ready,
    output issue_state_t     state,
    output logic             iss_valid,
    output logic [TAG_W-1:0] t1,
    output logic [TAG_W-1:0] t2
);
    issue_state_t state_n;
    logic [TAG_W-1:0] t1_n, t2_n, t1_clr, t2_clr;

    assign iss_valid = state == READY;

    // Tags clear on any matching broadcast; the WAIT->READY decision sees the cleared value.
    always_comb begin
        t1_clr = (wb_valid && wb_tag == t1) ? '0 : t1;
        t2_clr = (wb_valid && wb_tag == t2) ? '0 : t2;
        state_n = state;
        t1_n = t1_clr;
        t2_n = t2_clr;
        unique case (state)
            IDLE: if (accept) begin
                state_n = WAIT;
                t1_n = (wb_valid && disp_t1 == wb_tag) ? '0 : disp_t1;
                t2_n = (wb_valid && disp_t2 == wb_tag) ? '0 : disp_t2;
            end
            WAIT: state_n = (t1_clr == '0 && t2_clr == '0) ? READY : WAIT;
            READY: state_n = iss_ready ? EXEC : READY;
            EXEC: state_n = (wb_valid && wb_tag == TAG_W'(IDX + 1)) ? IDLE : EXEC;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            t1 <= '0;
            t2 <= '0;
        end else begin
            state <= state_n;
            t1 <= t1_n;
            t2 <= t2_n;
        end
    end
endmodule

// File: rtl/issue_s.sv
// issue_s: scalar issue stage; accept decode, per-FU slot fan-out and output packing.
module issue_s
    import datapath_pkg::*;
#(
    parameter int NUM_FU = 3,
    parameter int FU_W = 2,
    parameter int TAG_W = 2
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic                    disp_valid,
    input  logic [FU_W-1:0]         disp_fu,
    input  logic [TAG_W-1:0]        disp_t1,
    input  logic [TAG_W-1:0]        disp_t2,
    output logic                    disp_ready,
    input  logic                    wb_valid,
    input  logic [TAG_W-1:0]        wb_tag,
    output logic [NUM_FU-1:0]       iss_valid,
    input  logic [NUM_FU-1:0]       iss_ready,
    output logic [NUM_FU-1:0]       busy,
    output logic [NUM_FU*TAG_W-1:0] t1,
    output logic [NUM_FU*TAG_W-1:0] t2,
    output logic                    fust_en,
    output logic [FU_W-1:0]         fust_fu
);
    issue_state_t state [NUM_FU];
    logic [NUM_FU-1:0] idle;
    logic accept;

    // Out-of-range FU indices never match a slot, so they are never ready.
    always_comb begin
        disp_ready = 1'b0;
        for (int i = 0; i < NUM_FU; i++)
            if (disp_fu == FU_W'(i)) disp_ready = idle[i] & nRST;
    end

    assign accept = disp_valid & disp_ready;
    assign fust_en = accept;
    assign fust_fu = disp_fu;

    for (genvar i = 0; i < NUM_FU; i++) begin : g_slot
        issue_s_slot #(.TAG_W(TAG_W), .IDX(i)) u_slot (
            .CLK(CLK),
            .nRST(nRST),
            .accept(accept && disp_fu == FU_W'(i)),
            .disp_t1(disp_t1),
            .disp_t2(disp_t2),
            .wb_valid(wb_valid),
            .wb_tag(wb_tag),
            .iss_ready(iss_ready[i]),
            .state(state[i]),
            .iss_valid(iss_valid[i]),
            .t1(t1[i*TAG_W +: TAG_W]),
            .t2(t2[i*TAG_W +: TAG_W])
        );
        assign idle[i] = state[i] == IDLE;
        assign busy[i] = !idle[i];
    end
endmodule

// File: tb/tb_issue_s.sv
// tb_issue_s: directed scenarios then random traffic against a per-FU op model.
module tb_issue_s;
    logic       CLK = 1'b0;
    logic       nRST = 1'b0;
    logic       disp_valid = 1'b0;
    logic [1:0] disp_fu = '0;
    logic [1:0] disp_t1 = '0;
    logic [1:0] disp_t2 = '0;
    logic       disp_ready;
    logic       wb_valid = 1'b0;
    logic [1:0] wb_tag = '0;
    logic [2:0] iss_valid;
    logic [2:0] iss_ready = '0;
    logic [2:0] busy;
    logic [5:0] t1, t2;
    logic       fust_en;
    logic [1:0] fust_fu;

    int checks = 0;
    int errors = 0;

    // Op view per FU: has an op, op has been issued, op is visible as issuable, pending tags.
    bit         m_has[3], m_issued[3], m_offer[3];
    logic [1:0] m_t1[3], m_t2[3];

    issue_s dut (
        .CLK(CLK), .nRST(nRST),
        .disp_valid(disp_valid), .disp_fu(disp_fu), .disp_t1(disp_t1), .disp_t2(disp_t2),
        .disp_ready(disp_ready),
        .wb_valid(wb_valid), .wb_tag(wb_tag),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .busy(busy), .t1(t1), .t2(t2),
        .fust_en(fust_en), .fust_fu(fust_fu)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        for (int i = 0; i < 3; i++) begin
            m_has[i] = 0; m_issued[i] = 0; m_offer[i] = 0; m_t1[i] = 0; m_t2[i] = 0;
        end
    endfunction

    function automatic bit m_free(input logic [1:0] fu);
        return nRST && fu < 3 && !m_has[fu];
    endfunction

    task automatic check_all();
        logic [2:0] eb, ev;
        logic [5:0] e1, e2;
        for (int i = 0; i < 3; i++) begin
            eb[i] = m_has[i];
            ev[i] = m_offer[i];
            e1[i*2 +: 2] = m_t1[i];
            e2[i*2 +: 2] = m_t2[i];
        end
        chk("busy", 32'(busy), 32'(eb));
        chk("iss_valid", 32'(iss_valid), 32'(ev));
        chk("t1", 32'(t1), 32'(e1));
        chk("t2", 32'(t2), 32'(e2));
        chk("disp_ready", 32'(disp_ready), 32'(m_free(disp_fu)));
        chk("fust_en", 32'(fust_en), 32'(disp_valid && m_free(disp_fu)));
        chk("fust_fu", 32'(fust_fu), 32'(disp_fu));
    endtask

    function automatic void m_update();
        bit acc;
        logic [1:0] n1, n2;
        acc = disp_valid && m_free(disp_fu);
        for (int i = 0; i < 3; i++) begin
            n1 = (wb_valid && wb_tag == m_t1[i]) ? 2'd0 : m_t1[i];
            n2 = (wb_valid && wb_tag == m_t2[i]) ? 2'd0 : m_t2[i];
            if (!m_has[i]) begin
                m_t1[i] = n1; m_t2[i] = n2;
                if (acc && disp_fu == 2'(i)) begin
                    m_has[i] = 1; m_issued[i] = 0; m_offer[i] = 0;
                    m_t1[i] = (wb_valid && disp_t1 == wb_tag) ? 2'd0 : disp_t1;
                    m_t2[i] = (wb_valid && disp_t2 == wb_tag) ? 2'd0 : disp_t2;
                end
            end else if (m_issued[i]) begin
                m_t1[i] = n1; m_t2[i] = n2;
                if (wb_valid && wb_tag == 2'(i + 1)) begin
                    m_has[i] = 0; m_issued[i] = 0;
                end
            end else if (m_offer[i]) begin
                m_t1[i] = n1; m_t2[i] = n2;
                if (iss_ready[i]) begin
                    m_offer[i] = 0; m_issued[i] = 1;
                end
            end else begin
                m_t1[i] = n1; m_t2[i] = n2;
                m_offer[i] = (n1 == 0 && n2 == 0);
            end
        end
    endfunction

    task automatic step(input logic dv, input logic [1:0] df, input logic [1:0] d1,
                        input logic [1:0] d2, input logic wv, input logic [1:0] wt,
                        input logic [2:0] ir);
        @(negedge CLK);
        disp_valid = dv; disp_fu = df; disp_t1 = d1; disp_t2 = d2;
        wb_valid = wv; wb_tag = wt; iss_ready = ir;
        #1 check_all();
        @(posedge CLK);
        if (nRST) m_update(); else m_reset();
        #2;
    endtask

    task automatic idle_step();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        m_reset();
        repeat (2) idle_step();
        chk("reset_busy", 32'(busy), 0);
        chk("reset_ready", 32'(disp_ready), 0);
        @(negedge CLK) nRST = 1'b1;

        // Ready op on ALU: issue two cycles after accept, retire on its writeback
        step(1, 0, 0, 0, 0, 0, 0);
        chk("t1_wait_iv", 32'(iss_valid[0]), 0);
        idle_step();
        chk("t1_iv", 32'(iss_valid[0]), 1);
        step(0, 0, 0, 0, 0, 0, 3'b001);
        chk("t1_exec_busy", 32'(busy[0]), 1);
        chk("t1_exec_iv", 32'(iss_valid[0]), 0);

        // Dependent LD/ST op waits on ALU result
        step(1, 1, 1, 0, 0, 0, 0);
        chk("t2_t1", 32'(t1[3:2]), 1);
        chk("t2_iv0", 32'(iss_valid[1]), 0);
        idle_step();
        chk("t2_iv1", 32'(iss_valid[1]), 0);
        step(0, 0, 0, 0, 1, 1, 0);
        chk("t2_t1clr", 32'(t1[3:2]), 0);
        chk("t2_iv", 32'(iss_valid[1]), 1);
        chk("t2_retire", 32'(busy[0]), 0);
        step(0, 0, 0, 0, 0, 0, 3'b010);

        // Structural hazard on BRANCH
        step(1, 2, 2, 0, 0, 0, 0);
        chk("t3_busy", 32'(busy[2]), 1);
        step(1, 2, 0, 0, 0, 0, 0);
        chk("t3_ready", 32'(disp_ready), 0);
        chk("t3_fust", 32'(fust_en), 0);
        chk("t3_t1kept", 32'(t1[5:4]), 2);
        step(0, 0, 0, 0, 1, 2, 0);
        chk("t3_iv", 32'(iss_valid[2]), 1);
        step(0, 0, 0, 0, 0, 0, 3'b100);
        step(0, 0, 0, 0, 1, 3, 0);
        chk("t3_alldone", 32'(busy), 0);

        // Bypass of the tag completing in the accept cycle
        step(1, 2, 0, 1, 1, 1, 0);
        chk("t4_t2", 32'(t2[5:4]), 0);
        idle_step();
        chk("t4_iv", 32'(iss_valid[2]), 1);
        step(0, 0, 0, 0, 0, 0, 3'b100);
        step(0, 0, 0, 0, 1, 3, 0);

        // Back-pressure holds the request
        step(1, 0, 0, 0, 0, 0, 0);
        repeat (6) idle_step();
        chk("t5_iv", 32'(iss_valid[0]), 1);
        chk("t5_busy", 32'(busy[0]), 1);
        step(0, 0, 0, 0, 0, 0, 3'b001);
        chk("t5_exec", 32'(iss_valid[0]), 0);

        // Asynchronous reset with ALU executing and LD/ST waiting
        step(1, 1, 1, 2, 0, 0, 0);
        @(negedge CLK);
        disp_valid = 0; wb_valid = 0; iss_ready = 0;
        #2 nRST = 1'b0;
        #1;
        chk("t6_busy", 32'(busy), 0);
        chk("t6_t1", 32'(t1), 0);
        chk("t6_t2", 32'(t2), 0);
        chk("t6_ready", 32'(disp_ready), 0);
        m_reset();
        idle_step();
        @(negedge CLK) nRST = 1'b1;

        repeat (3000) begin
            step($urandom_range(0, 1), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 2'($urandom_range(0, 3)), $urandom_range(0, 2) != 0,
                 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
